heat_node_array: RTL

HEAT_NODE_ARRAY -- requirements
Module: heat_node_array

---
 rtl/heat_node_array_if.sv | 30 +++
 rtl/heat_node_array.sv | 132 +++++++++++++
 2 files changed

// File: rtl/heat_node_array_if.sv
// Command/data bundle for heat_node_array: host-side command handshake,
// packed neighbour inputs and packed node/status outputs.
interface heat_node_array_if #(
    parameter int W   = 32,
    parameter int NCH = 4
);
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        command;
    logic [CW-1:0]     ch_sel;
    logic [W-1:0]      set_val;
    logic [NCH*W-1:0]  left_val;
    logic [NCH*W-1:0]  right_val;
    logic [NCH*W-1:0]  nodeval;
    logic              busy;
    logic              done;
    logic              sat_flag;

    modport master (
        output cmd_valid, command, ch_sel, set_val, left_val, right_val,
        input  cmd_ready, nodeval, busy, done, sat_flag
    );

    modport slave (
        input  cmd_valid, command, ch_sel, set_val, left_val, right_val,
        output cmd_ready, nodeval, busy, done, sat_flag
    );
endinterface

// File: rtl/heat_node_array.sv
// Explicit 1-D heat-equation node array: NCH channels each updated as
// v += coef * (L - 2v + R) in signed fixed point, one channel per 3 cycles.
module heat_node_array #(
    parameter int W    = 32,
    parameter int FRAC = 16,
    parameter int NCH  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    heat_node_array_if.slave bus
);
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int PW = 2 * W + 2;

    typedef enum logic [1:0] {IDLE, LAP, MUL, WB} state_t;

    state_t                state;
    logic signed [W-1:0]   value  [NCH];
    logic signed [W-1:0]   coef   [NCH];
    logic signed [W-1:0]   snap_l [NCH];
    logic signed [W-1:0]   snap_r [NCH];
    logic [NCH-1:0]        lock;
    logic [CW-1:0]         idx;
    logic signed [W+1:0]   lap;
    logic signed [PW-1:0]  prod;
    logic                  busy;
    logic                  done;
    logic                  sat_flag;

    logic                  ready;
    logic                  sel_ok;
    logic signed [W-1:0]   cur_v;
    logic signed [W-1:0]   cur_c;
    logic signed [W+1:0]   lap_next;
    logic signed [PW-1:0]  prod_full;
    logic signed [PW:0]    sum;
    logic                  ovf;
    logic signed [W-1:0]   wb_val;

    assign ready         = !busy;
    assign bus.cmd_ready = ready;
    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.sat_flag  = sat_flag;

    always_comb begin
        bus.nodeval = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            bus.nodeval[i*W +: W] = value[i];
        end
    end

    always_comb begin
        sel_ok    = (32'(bus.ch_sel) < NCH);
        cur_v     = value[idx];
        cur_c     = coef[idx];
        lap_next  = (W+2)'(snap_l[idx]) - ((W+2)'(cur_v) <<< 1) + (W+2)'(snap_r[idx]);
        prod_full = PW'(cur_c) * PW'(lap);
        sum       = (PW+1)'(cur_v) + (PW+1)'(prod);
        // Representable only when every bit from the W-bit sign position up agrees.
        ovf       = !((&sum[PW:W-1]) || !(|sum[PW:W-1]));
        wb_val    = ovf ? (sum[PW] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}})
                        : sum[W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            lock     <= '0;
            idx      <= '0;
            lap      <= '0;
            prod     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sat_flag <= 1'b0;
            for (int unsigned i = 0; i < NCH; i++) begin
                value[i]  <= '0;
                coef[i]   <= '0;
                snap_l[i] <= '0;
                snap_r[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.cmd_valid && ready) begin
                        case (bus.command)
                            3'd1: if (sel_ok) value[bus.ch_sel] <= bus.set_val;
                            3'd2: if (sel_ok) coef[bus.ch_sel]  <= bus.set_val;
                            3'd3: begin
                                for (int unsigned i = 0; i < NCH; i++) begin
                                    snap_l[i] <= bus.left_val[i*W +: W];
                                    snap_r[i] <= bus.right_val[i*W +: W];
                                end
                                idx   <= '0;
                                busy  <= 1'b1;
                                state <= LAP;
                            end
                            3'd4: if (sel_ok) lock[bus.ch_sel] <= 1'b1;
                            3'd5: if (sel_ok) lock[bus.ch_sel] <= 1'b0;
                            3'd6: sat_flag <= 1'b0;
                            default: ;
                        endcase
                    end
                end
                LAP: begin
                    lap   <= lap_next;
                    state <= MUL;
                end
                MUL: begin
                    prod  <= prod_full >>> FRAC;
                    state <= WB;
                end
                WB: begin
                    if (!lock[idx]) begin
                        value[idx] <= wb_val;
                        if (ovf) sat_flag <= 1'b1;
                    end
                    if (32'(idx) == NCH - 1) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= LAP;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
